serial2d_mac_seq: RTL and testbench

Parametrised 2D bit-serial multiply-accumulate unit with an on-block sequencer. It accepts one unsigned activation and one signed weight per valid/ready handshake. It walks all activation×weight bit pairs in diagonal (Loom) order, one pair per clock, and accumulates the MSB-aligned product into a signed accumulator. This replaces the externally driven shift/sign/select control of the previous serial 2D MAC: precision is chosen per operand at runtime rather than through a fixed 4-bit mode set.

---
 rtl/serial2d_mac_seq.sv | 196 +++++++++++++++++++
 tb/tb_serial2d_mac_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/serial2d_mac_seq.sv
// Bit-serial 2D multiply-accumulate with an internal diagonal (Loom-order) sequencer.
// Optional feature: define SERIAL2D_SAT_EN for a saturating final add (default wraps).
module serial2d_mac_seq #(
    parameter int  A_MAX     = 8,
    parameter int  W_MAX     = 8,
    parameter int  HEADROOM  = 4,
    localparam int ACC_WIDTH = A_MAX + W_MAX + HEADROOM,
    localparam int PW        = $clog2(((A_MAX > W_MAX) ? A_MAX : W_MAX) + 1)
) (
    input  logic                        clk_fast,
    input  logic                        rst,
    input  logic [PW-1:0]               a_prec,
    input  logic [PW-1:0]               w_prec,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [A_MAX-1:0]            a,
    input  logic [W_MAX-1:0]            w,
    input  logic                        acc_clr,
    output logic                        out_valid,
    output logic                        busy,
    output logic signed [ACC_WIDTH-1:0] z
);

    // Counter width holds any diagonal index up to A_MAX+W_MAX-2.
    localparam int CW   = PW + 1;
    localparam int PWID = A_MAX + W_MAX + 1;

    localparam logic [PW-1:0]        A_MAX_P = PW'(A_MAX);
    localparam logic [PW-1:0]        W_MAX_P = PW'(W_MAX);
    localparam logic [PW-1:0]        TWO_P   = PW'(32'd2);
    localparam logic [PW-1:0]        ZERO_P  = {PW{1'b0}};
    localparam logic [CW-1:0]        A_MAX_C = CW'(A_MAX);
    localparam logic [CW-1:0]        W_MAX_C = CW'(W_MAX);
    localparam logic [CW-1:0]        ZERO_C  = {CW{1'b0}};
    localparam logic [CW-1:0]        ONE_C   = CW'(32'd1);
    localparam logic [CW-1:0]        TWO_C   = CW'(32'd2);
    localparam logic signed [PWID-1:0] P_ZERO = {PWID{1'b0}};
    localparam logic signed [ACC_WIDTH-1:0] Z_ZERO = {ACC_WIDTH{1'b0}};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                        state_r, state_s;
    logic [A_MAX-1:0]              a_r;
    logic [W_MAX-1:0]              w_r;
    logic [PW-1:0]                 m_r, n_r;
    logic [CW-1:0]                 k_r, j_r;
    logic signed [PWID-1:0]        p_r;
    logic signed [ACC_WIDTH-1:0]   z_r;
    logic                          out_valid_r;

    logic                          hs_s;
    logic [PW-1:0]                 m_in_s, n_in_s;
    logic [CW-1:0]                 m_ext_s, n_ext_s, n_last_s, i_s, j_max_s, k_nxt_s, j_start_s, shamt_s;
    logic                          last_s, bit_s;
    logic [A_MAX-1:0]              a_sel_s;
    logic [W_MAX-1:0]              w_sel_s;
    logic signed [PWID-1:0]        weight_s, term_s, p_nxt_s;
    logic signed [ACC_WIDTH-1:0]   prod_ext_s, shifted_s, base_s, z_add_s;
`ifdef SERIAL2D_SAT_EN
    logic signed [ACC_WIDTH:0]     sum_s;
`endif

    assign in_ready  = (state_r == IDLE) && !rst;
    assign busy      = (state_r == RUN);
    assign out_valid = out_valid_r;
    assign z         = z_r;
    assign hs_s      = in_valid && (state_r == IDLE);

    // Effective precisions: out-of-range requests fall back to the maximum.
    always_comb begin
        m_in_s = a_prec;
        n_in_s = w_prec;
        if ((a_prec == ZERO_P) || (a_prec > A_MAX_P)) begin
            m_in_s = A_MAX_P;
        end else begin
            m_in_s = a_prec;
        end
        if ((w_prec < TWO_P) || (w_prec > W_MAX_P)) begin
            n_in_s = W_MAX_P;
        end else begin
            n_in_s = w_prec;
        end
    end

    // Diagonal walk, partial-product update and final accumulate.
    always_comb begin
        m_ext_s   = {1'b0, m_r};
        n_ext_s   = {1'b0, n_r};
        n_last_s  = n_ext_s - ONE_C;
        i_s       = k_r - j_r;
        j_max_s   = (k_r < n_last_s) ? k_r : n_last_s;
        k_nxt_s   = k_r + ONE_C;
        // j restarts at max(0, k+1-m+1)
        j_start_s = (k_nxt_s >= m_ext_s) ? (k_nxt_s - m_ext_s + ONE_C) : ZERO_C;
        last_s    = (state_r == RUN) && (k_r == (m_ext_s + n_ext_s - TWO_C)) && (j_r == n_last_s);
        a_sel_s   = A_MAX'(1'b1) << i_s;
        w_sel_s   = W_MAX'(1'b1) << j_r;
        bit_s     = (|(a_r & a_sel_s)) && (|(w_r & w_sel_s));
        weight_s  = PWID'(1'b1) << (i_s + j_r);
        term_s    = bit_s ? weight_s : P_ZERO;
        // the weight's top bit carries negative significance
        if (j_r == n_last_s) begin
            p_nxt_s = p_r - term_s;
        end else begin
            p_nxt_s = p_r + term_s;
        end
        shamt_s    = (A_MAX_C - m_ext_s) + (W_MAX_C - n_ext_s);
        prod_ext_s = ACC_WIDTH'(p_nxt_s);
        shifted_s  = prod_ext_s <<< shamt_s;
        base_s     = acc_clr ? Z_ZERO : z_r;
`ifdef SERIAL2D_SAT_EN
        sum_s = {base_s[ACC_WIDTH-1], base_s} + {shifted_s[ACC_WIDTH-1], shifted_s};
        if (sum_s[ACC_WIDTH] != sum_s[ACC_WIDTH-1]) begin
            z_add_s = sum_s[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end else begin
            z_add_s = sum_s[ACC_WIDTH-1:0];
        end
`else
        z_add_s = base_s + shifted_s;
`endif
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (hs_s) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = RUN;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_fast) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand capture, sequencer counters, partial product and accumulator.
    always_ff @(posedge clk_fast) begin
        if (rst) begin
            a_r         <= {A_MAX{1'b0}};
            w_r         <= {W_MAX{1'b0}};
            m_r         <= ZERO_P;
            n_r         <= ZERO_P;
            k_r         <= ZERO_C;
            j_r         <= ZERO_C;
            p_r         <= P_ZERO;
            z_r         <= Z_ZERO;
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= last_s;
            if (hs_s) begin
                a_r <= a;
                w_r <= w;
                m_r <= m_in_s;
                n_r <= n_in_s;
                p_r <= P_ZERO;
                k_r <= ZERO_C;
                j_r <= ZERO_C;
            end else if (state_r == RUN) begin
                p_r <= p_nxt_s;
                if (j_r == j_max_s) begin
                    k_r <= k_nxt_s;
                    j_r <= j_start_s;
                end else begin
                    j_r <= j_r + ONE_C;
                end
            end
            if (last_s) begin
                z_r <= z_add_s;
            end else if (acc_clr) begin
                z_r <= Z_ZERO;
            end
        end
    end

endmodule

// File: tb/tb_serial2d_mac_seq.sv
// Randomised self-checking bench for serial2d_mac_seq against an arithmetic reference model.
module tb_serial2d_mac_seq;

    localparam int A_MAX   = 8;
    localparam int W_MAX   = 8;
    localparam int ACC     = 20;
    localparam int PW      = 4;
    localparam int MAX_CYC = 200;

    logic                  clk_fast = 1'b0;
    logic                  rst = 1'b1;
    logic [PW-1:0]         a_prec = '0;
    logic [PW-1:0]         w_prec = '0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [A_MAX-1:0]      a = '0;
    logic [W_MAX-1:0]      w = '0;
    logic                  acc_clr = 1'b0;
    logic                  out_valid;
    logic                  busy;
    logic signed [ACC-1:0] z;

    int     n_vec = 0;
    int     n_err = 0;
    longint z_model = 0;

    serial2d_mac_seq #(.A_MAX(A_MAX), .W_MAX(W_MAX), .HEADROOM(4)) dut (
        .clk_fast (clk_fast),
        .rst      (rst),
        .a_prec   (a_prec),
        .w_prec   (w_prec),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .w        (w),
        .acc_clr  (acc_clr),
        .out_valid(out_valid),
        .busy     (busy),
        .z        (z)
    );

    always #5 clk_fast = ~clk_fast;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint acc_add(input longint base, input longint p);
        longint s;
        s = base + p;
`ifdef SERIAL2D_SAT_EN
        if (s > (longint'(1) << (ACC-1)) - 1) s = (longint'(1) << (ACC-1)) - 1;
        if (s < -(longint'(1) << (ACC-1)))    s = -(longint'(1) << (ACC-1));
`else
        s = s & ((longint'(1) << ACC) - 1);
        if (s >= (longint'(1) << (ACC-1))) s = s - (longint'(1) << ACC);
`endif
        return s;
    endfunction

    // clr_at: 0 none, >0 acc_clr sampled at that RUN edge, <0 random RUN edge
    task automatic run_product(input int ai, input int wi, input int mp, input int np,
                               input int clr_at, input bit scramble);
        int     me, ne, mn, got_cyc, clr_c;
        bit     bad_run;
        longint av, wv, prod;
        me = (mp == 0 || mp > A_MAX) ? A_MAX : mp;
        ne = (np < 2 || np > W_MAX) ? W_MAX : np;
        mn = me * ne;
        av = longint'(ai) & ((longint'(1) << me) - 1);
        wv = longint'(wi) & ((longint'(1) << ne) - 1);
        if (wv >= (longint'(1) << (ne - 1))) wv = wv - (longint'(1) << ne);
        prod  = (av * wv) * (longint'(1) << ((A_MAX - me) + (W_MAX - ne)));
        clr_c = (clr_at < 0) ? int'($urandom_range(1, mn)) : clr_at;

        a        = ai[A_MAX-1:0];
        w        = wi[W_MAX-1:0];
        a_prec   = mp[PW-1:0];
        w_prec   = np[PW-1:0];
        in_valid = 1'b1;
        chk("ready_idle", longint'(in_ready), 1);
        @(posedge clk_fast); #1;
        in_valid = 1'b0;
        chk("ov_pulse", longint'(out_valid), 0);
        if (scramble) begin
            a      = A_MAX'($urandom);
            w      = W_MAX'($urandom);
            a_prec = PW'($urandom_range(0, 15));
            w_prec = PW'($urandom_range(0, 15));
        end
        got_cyc = 0;
        bad_run = 1'b0;
        for (int c = 1; c <= MAX_CYC && got_cyc == 0; c++) begin
            acc_clr = (c == clr_c);
            @(posedge clk_fast); #1;
            acc_clr = 1'b0;
            if (out_valid) got_cyc = c;
            else if (!busy || in_ready) bad_run = 1'b1;
        end
        if (clr_c > 0) z_model = 0;
        z_model = acc_add(z_model, prod);
        chk("run_cycles", got_cyc, mn);
        chk("run_flags", longint'(bad_run), 0);
        chk("ready_at_ov", longint'(in_ready), 1);
        chk("z_product", z, z_model);
    endtask

    task automatic idle_clear();
        acc_clr = 1'b1;
        @(posedge clk_fast); #1;
        acc_clr = 1'b0;
        z_model = 0;
        chk("idle_clr", z, 0);
    endtask

    initial begin
        bit seen;
        int mp, np;
        // reset
        repeat (3) @(posedge clk_fast);
        #1;
        chk("rst_z", z, 0);
        chk("rst_ov", longint'(out_valid), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_ready", longint'(in_ready), 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", longint'(in_ready), 1);

        run_product(255, 128, 8, 8, 0, 1'b0);
        chk("plan_8x8", z, -32640);

        idle_clear();
        run_product(15, 8, 4, 4, 0, 1'b0);
        chk("plan_4x4", z, -30720);
        run_product(3, 2, 2, 2, 0, 1'b0);
        chk("plan_2x2", z, -55296);

        idle_clear();
        run_product(200, 7, 8, 4, 0, 1'b0);
        chk("plan_8x4", z, 22400);
        run_product(1, 3, 8, 2, 0, 1'b0);
        chk("plan_8x2", z, 22336);

        idle_clear();
        for (int r = 0; r < 17; r++) run_product(255, 128, 8, 8, 0, 1'b0);
`ifdef SERIAL2D_SAT_EN
        chk("plan_17x", z, -524288);
`else
        chk("plan_17x", z, 493696);
`endif

        idle_clear();
        run_product(125, 8, 8, 8, 0, 1'b0);
        chk("plan_1000", z, 1000);
        run_product(3, 1, 2, 2, 4, 1'b0);
        chk("plan_clr_add", z, 12288);
        idle_clear();

        // reset in the middle of a product
        run_product(20, 5, 8, 8, 0, 1'b0);
        a = 8'd1; w = 8'd1; a_prec = 4'd8; w_prec = 4'd8; in_valid = 1'b1;
        @(posedge clk_fast); #1;
        in_valid = 1'b0;
        repeat (9) begin
            @(posedge clk_fast); #1;
        end
        rst = 1'b1;
        #1;
        chk("midrst_ready", longint'(in_ready), 0);
        @(posedge clk_fast); #1;
        rst = 1'b0;
        z_model = 0;
        chk("midrst_z", z, 0);
        chk("midrst_ov", longint'(out_valid), 0);
        chk("midrst_busy", longint'(busy), 0);
        @(posedge clk_fast); #1;
        chk("midrst_ready_after", longint'(in_ready), 1);
        seen = 1'b0;
        repeat (70) begin
            @(posedge clk_fast); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("midrst_no_ov", longint'(seen), 0);
        run_product(1, 1, 8, 8, 0, 1'b0);
        chk("plan_after_rst", z, 1);

        // randomised products, including illegal precisions and mid-run clears
        for (int r = 0; r < 25; r++) begin
            mp = int'($urandom_range(0, 15));
            np = int'($urandom_range(0, 15));
            run_product(int'($urandom), int'($urandom), mp, np,
                        ($urandom_range(0, 3) == 0) ? -1 : 0, 1'b1);
            if ($urandom_range(0, 7) == 0) idle_clear();
        end
        @(posedge clk_fast); #1;
        chk("final_ov_low", longint'(out_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
